// File: rtl/fifo_arbiter.sv
// fifo_arbiter
//
// Drains NUM_IN source FIFOs into one destination FIFO, one word per cycle.
// A round-robin search picks a non-empty source. The arbiter pops it, and the
// word the source registered on the pop edge is pushed to the destination one
// cycle later. At most one word is in flight at any time. Destination
// full/almost_full throttle the pops, and any FIFO error parks the block in
// ERROR until reset.
//
// Configuration macro:
//   FIXED_PRIORITY_EN - when defined, the search always starts at index 0 and
//                       there is no rotating pointer.
//
// Ports:
//   clk             - clock, rising edge
//   reset           - asynchronous, active-low reset
//   in_empty        - per-source empty flags
//   in_error        - per-source error flags
//   in_data         - per-source registered data; source i at [i*DATA_W +: DATA_W]
//   in_pop          - per-source read_enable, one-hot or zero (combinational)
//   out_full        - destination full
//   out_almost_full - destination almost full (one free entry)
//   out_error       - destination error
//   out_push        - destination write_enable
//   out_data        - word for the destination
//   estado          - 0 IDLE, 1 ACTIVE, 2 ERROR
//   idle            - estado == IDLE
//   err             - estado == ERROR
//   fwd_count       - words forwarded since reset, wrapping 16-bit counter
module fifo_arbiter #(
   parameter int unsigned DATA_W = 10,
   parameter int unsigned NUM_IN = 4,
   parameter int unsigned PTR_W  = 2
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [NUM_IN-1:0]        in_empty,
   input  logic [NUM_IN-1:0]        in_error,
   input  logic [NUM_IN*DATA_W-1:0] in_data,
   output logic [NUM_IN-1:0]        in_pop,
   input  logic                     out_full,
   input  logic                     out_almost_full,
   input  logic                     out_error,
   output logic                     out_push,
   output logic [DATA_W-1:0]        out_data,
   output logic [1:0]               estado,
   output logic                     idle,
   output logic                     err,
   output logic [15:0]              fwd_count
);

   typedef enum logic [1:0] {
      StIdle   = 2'd0,
      StActive = 2'd1,
      StError  = 2'd2
   } state_e;

   state_e           state_q;
   logic [PTR_W-1:0] rr_ptr;
   logic [PTR_W-1:0] src_q;
   logic             pend_q;
   logic [15:0]      fwd_q;

   logic [PTR_W-1:0] grant_idx;
   logic [PTR_W-1:0] idx;
   logic             found;
   logic             any_err;
   logic             grant;

`ifdef FIXED_PRIORITY_EN
   assign rr_ptr = '0;
`else
   logic [PTR_W-1:0] rr_q;

   // The next search starts just past the source granted last.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rr_q <= '0;
      end else if (grant) begin
         rr_q <= grant_idx + PTR_W'(1);
      end
   end

   assign rr_ptr = rr_q;
`endif

   // First non-empty source at or after rr_ptr. NUM_IN is a power of two, so
   // the PTR_W-bit add wraps modulo NUM_IN.
   always_comb begin
      found     = 1'b0;
      grant_idx = '0;
      idx       = '0;
      for (int unsigned k = 0; k < NUM_IN; k++) begin
         idx = rr_ptr + PTR_W'(k);
         if (!found && !in_empty[idx]) begin
            found     = 1'b1;
            grant_idx = idx;
         end
      end
   end

   assign any_err = (|in_error) | out_error;

   // Holding off on almost_full while a push is pending keeps the in-flight
   // word from landing on a full destination.
   assign grant = found && (state_q != StError) && !any_err && !out_full &&
                  !(out_almost_full && pend_q);

   always_comb begin
      in_pop = '0;
      for (int unsigned i = 0; i < NUM_IN; i++) begin
         in_pop[i] = grant && (grant_idx == PTR_W'(i));
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= StIdle;
         src_q   <= '0;
         pend_q  <= 1'b0;
         fwd_q   <= '0;
      end else begin
         pend_q <= grant;
         if (grant) begin
            src_q <= grant_idx;
         end
         // A pending push completes even when an error arrives.
         if (pend_q) begin
            fwd_q <= fwd_q + 16'd1;
         end
         if (any_err || (state_q == StError)) begin
            state_q <= StError;
         end else if (grant || pend_q) begin
            state_q <= StActive;
         end else begin
            state_q <= StIdle;
         end
      end
   end

   assign out_push  = pend_q;
   assign out_data  = in_data[int'(src_q) * DATA_W +: DATA_W];
   assign estado    = state_q;
   assign idle      = (state_q == StIdle);
   assign err       = (state_q == StError);
   assign fwd_count = fwd_q;

endmodule

// File: tb/tb_fifo_arbiter.sv
// Bench for fifo_arbiter: behavioural source FIFOs and a depth-8 destination
// occupancy model surround the DUT; directed scenarios check pops, pushes and
// state against hand-computed expectations.
module tb_fifo_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [3:0]  in_empty;
   logic [3:0]  in_error;
   logic [39:0] in_data;
   logic [3:0]  in_pop;
   logic        out_full;
   logic        out_almost_full;
   logic        out_error;
   logic        out_push;
   logic [9:0]  out_data;
   logic [1:0]  estado;
   logic        idle;
   logic        err;
   logic [15:0] fwd_count;

   // Environment controls.
   logic        force_full;
   logic        ld_en;
   logic [1:0]  ld_idx;
   logic [9:0]  ld_val;
   logic        dst_drain;
   logic        dst_set_en;
   logic [3:0]  dst_set_val;

   // Environment state.
   logic [9:0]  src_mem [4][8];
   logic [3:0]  src_cnt [4];
   logic [2:0]  src_rd  [4];
   logic [2:0]  src_wr  [4];
   logic [9:0]  src_q   [4];
   logic [3:0]  dst_cnt;
   int          push_viol;
   int          pop_viol;

   int          n_checks = 0;
   int          n_fail   = 0;

   always #5 clk = ~clk;

   fifo_arbiter #(
      .DATA_W (10),
      .NUM_IN (4),
      .PTR_W  (2)
   ) dut (
      .clk             (clk),
      .reset           (rst_n),
      .in_empty        (in_empty),
      .in_error        (in_error),
      .in_data         (in_data),
      .in_pop          (in_pop),
      .out_full        (out_full),
      .out_almost_full (out_almost_full),
      .out_error       (out_error),
      .out_push        (out_push),
      .out_data        (out_data),
      .estado          (estado),
      .idle            (idle),
      .err             (err),
      .fwd_count       (fwd_count)
   );

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 4; i++) begin
            src_cnt[i] <= 4'd0;
            src_rd[i]  <= 3'd0;
            src_wr[i]  <= 3'd0;
            src_q[i]   <= 10'd0;
         end
         dst_cnt   <= 4'd0;
         push_viol <= 0;
         pop_viol  <= 0;
      end else begin
         for (int i = 0; i < 4; i++) begin
            if (ld_en && ld_idx == 2'(i)) begin
               src_mem[i][src_wr[i]] <= ld_val;
               src_wr[i] <= src_wr[i] + 3'd1;
            end
            if (in_pop[i] && src_cnt[i] != 4'd0) begin
               src_q[i]  <= src_mem[i][src_rd[i]];
               src_rd[i] <= src_rd[i] + 3'd1;
            end
            if (in_pop[i] && src_cnt[i] == 4'd0) pop_viol <= pop_viol + 1;
            src_cnt[i] <= src_cnt[i] + {3'd0, (ld_en && ld_idx == 2'(i))}
                          - {3'd0, (in_pop[i] && src_cnt[i] != 4'd0)};
         end
         if (out_push && dst_cnt >= 4'd8) push_viol <= push_viol + 1;
         if (dst_set_en) dst_cnt <= dst_set_val;
         else dst_cnt <= dst_cnt + {3'd0, out_push} - {3'd0, (dst_drain && dst_cnt != 4'd0)};
      end
   end

   always_comb begin
      in_empty = '1;
      in_data  = '0;
      for (int i = 0; i < 4; i++) begin
         in_empty[i]         = (src_cnt[i] == 4'd0);
         in_data[i*10 +: 10] = src_q[i];
      end
   end

   assign out_full        = force_full | (dst_cnt >= 4'd8);
   assign out_almost_full = (dst_cnt == 4'd7);

   task automatic load_word(input int idx, input logic [9:0] val);
      ld_en  = 1'b1;
      ld_idx = 2'(idx);
      ld_val = val;
      @(posedge clk); #1;
      ld_en  = 1'b0;
   endtask

   task automatic dst_preset(input logic [3:0] v);
      dst_set_en  = 1'b1;
      dst_set_val = v;
      @(posedge clk); #1;
      dst_set_en  = 1'b0;
   endtask

   task automatic test_reset();
      #2;
      n_checks++;
      if ({in_pop, out_push} !== 5'b0) begin
         n_fail++;
         $display("FAIL reset_pop_push: got %b, want 00000", {in_pop, out_push});
      end
      n_checks++;
      if ({estado, idle, err} !== 4'b0010) begin
         n_fail++;
         $display("FAIL reset_state: got estado=%0d idle=%b err=%b, want 0 1 0", estado, idle, err);
      end
      n_checks++;
      if (fwd_count !== 16'd0) begin
         n_fail++;
         $display("FAIL reset_fwd_count: got %0d, want 0", fwd_count);
      end
      n_checks++;
      if (out_data !== in_data[9:0]) begin
         n_fail++;
         $display("FAIL reset_out_data: got %h, want %h", out_data, in_data[9:0]);
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      force_full = 1'b0;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         n_checks++;
         if ({idle, in_pop, out_push} !== 6'b100000) begin
            n_fail++;
            $display("FAIL reset_idle cycle %0d: got idle=%b pop=%b push=%b, want 1 0000 0",
                     k, idle, in_pop, out_push);
         end
         @(posedge clk); #1;
      end
   endtask

`ifdef FIXED_PRIORITY_EN
   task automatic test_fixed_priority();
      logic [3:0] ep;
      logic       epu;
      logic [9:0] ed;
      force_full = 1'b1;
      dst_drain  = 1'b1;
      for (int j = 0; j < 4; j++) begin
         load_word(3, 10'(10'h340 + j));
         load_word(0, 10'(10'h040 + j));
      end
      force_full = 1'b0;
      for (int k = 0; k < 10; k++) begin
         ep  = (k < 4) ? 4'b0001 : ((k < 8) ? 4'b1000 : 4'b0000);
         epu = (k >= 1 && k <= 8);
         ed  = (k <= 4) ? 10'(10'h040 + k - 1) : 10'(10'h340 + k - 5);
         @(negedge clk);
         n_checks++;
         if ({in_pop, out_push} !== {ep, epu}) begin
            n_fail++;
            $display("FAIL fixed_pop_push cycle %0d: got pop=%b push=%b, want pop=%b push=%b",
                     k, in_pop, out_push, ep, epu);
         end
         if (epu) begin
            n_checks++;
            if (out_data !== ed) begin
               n_fail++;
               $display("FAIL fixed_data cycle %0d: got %h, want %h", k, out_data, ed);
            end
         end
         @(posedge clk); #1;
      end
   endtask
`else
   task automatic test_round_robin();
      logic [3:0] ep;
      logic       epu;
      logic [9:0] ed;
      force_full = 1'b1;
      dst_drain  = 1'b1;
      for (int j = 0; j < 3; j++) begin
         for (int i = 0; i < 4; i++) load_word(i, 10'((i << 8) | (j + 1)));
      end
      force_full = 1'b0;
      for (int k = 0; k < 15; k++) begin
         ep  = (k < 12) ? 4'(1 << (k % 4)) : 4'd0;
         epu = (k >= 1 && k <= 12);
         ed  = 10'((((k - 1) % 4) << 8) | ((k - 1) / 4 + 1));
         @(negedge clk);
         n_checks++;
         if ({in_pop, out_push} !== {ep, epu}) begin
            n_fail++;
            $display("FAIL rr_pop_push cycle %0d: got pop=%b push=%b, want pop=%b push=%b",
                     k, in_pop, out_push, ep, epu);
         end
         if (epu) begin
            n_checks++;
            if (out_data !== ed) begin
               n_fail++;
               $display("FAIL rr_data cycle %0d: got %h, want %h", k, out_data, ed);
            end
         end
         if (k == 5) begin
            n_checks++;
            if (estado !== 2'd1) begin
               n_fail++;
               $display("FAIL rr_active: got estado=%0d, want 1", estado);
            end
         end
         if (k == 14) begin
            n_checks++;
            if ({estado, idle, fwd_count} !== {2'd0, 1'b1, 16'd12}) begin
               n_fail++;
               $display("FAIL rr_done: got estado=%0d idle=%b fwd=%0d, want 0 1 12",
                        estado, idle, fwd_count);
            end
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_single();
      logic [3:0] ep;
      logic       epu;
      logic [9:0] ed;
      force_full = 1'b1;
      load_word(2, 10'h2AA);
      force_full = 1'b0;
      for (int k = 0; k < 4; k++) begin
         ep  = (k == 0) ? 4'b0100 : 4'b0000;
         epu = (k == 1);
         @(negedge clk);
         n_checks++;
         if ({in_pop, out_push} !== {ep, epu}) begin
            n_fail++;
            $display("FAIL single_pop_push cycle %0d: got pop=%b push=%b, want pop=%b push=%b",
                     k, in_pop, out_push, ep, epu);
         end
         if (epu) begin
            n_checks++;
            if (out_data !== 10'h2AA) begin
               n_fail++;
               $display("FAIL single_data: got %h, want 2aa", out_data);
            end
         end
         @(posedge clk); #1;
      end
      // Search must now start at index 3, so FIFO3 beats FIFO0.
      force_full = 1'b1;
      load_word(0, 10'h0AA);
      load_word(3, 10'h3AA);
      force_full = 1'b0;
      for (int k = 0; k < 4; k++) begin
         ep  = (k == 0) ? 4'b1000 : ((k == 1) ? 4'b0001 : 4'b0000);
         epu = (k == 1 || k == 2);
         ed  = (k == 1) ? 10'h3AA : 10'h0AA;
         @(negedge clk);
         n_checks++;
         if ({in_pop, out_push} !== {ep, epu}) begin
            n_fail++;
            $display("FAIL next_start cycle %0d: got pop=%b push=%b, want pop=%b push=%b",
                     k, in_pop, out_push, ep, epu);
         end
         if (epu) begin
            n_checks++;
            if (out_data !== ed) begin
               n_fail++;
               $display("FAIL next_start_data cycle %0d: got %h, want %h", k, out_data, ed);
            end
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_throttle();
      logic [3:0] ep;
      logic       epu;
      logic [9:0] ed;
      force_full = 1'b1;
      dst_drain  = 1'b0;
      for (int j = 0; j < 4; j++) begin
         for (int i = 0; i < 4; i++) load_word(i, 10'((i << 8) | (16 + j)));
      end
      dst_preset(4'd6);
      force_full = 1'b0;
      for (int k = 0; k < 11; k++) begin
         ed = 10'h000;
         case (k)
            0:       begin ep = 4'b0010; epu = 1'b0; end
            1:       begin ep = 4'b0100; epu = 1'b1; ed = 10'h110; end
            2:       begin ep = 4'b0000; epu = 1'b1; ed = 10'h210; end
            7:       begin ep = 4'b1000; epu = 1'b0; end
            8:       begin ep = 4'b0000; epu = 1'b1; ed = 10'h310; end
            default: begin ep = 4'b0000; epu = 1'b0; end
         endcase
         dst_drain = (k == 6);
         @(negedge clk);
         n_checks++;
         if ({in_pop, out_push} !== {ep, epu}) begin
            n_fail++;
            $display("FAIL throttle_pop_push cycle %0d: got pop=%b push=%b, want pop=%b push=%b",
                     k, in_pop, out_push, ep, epu);
         end
         if (epu) begin
            n_checks++;
            if (out_data !== ed) begin
               n_fail++;
               $display("FAIL throttle_data cycle %0d: got %h, want %h", k, out_data, ed);
            end
         end
         @(posedge clk); #1;
      end
      n_checks++;
      if (push_viol !== 0 || pop_viol !== 0) begin
         n_fail++;
         $display("FAIL flow_violations: got push_when_full=%0d pop_when_empty=%0d, want 0 0",
                  push_viol, pop_viol);
      end
   endtask

   task automatic test_error();
      force_full = 1'b1;
      dst_preset(4'd0);
      dst_drain  = 1'b1;
      force_full = 1'b0;
      for (int k = 0; k < 5; k++) begin
         in_error = (k == 1) ? 4'b0010 : 4'b0000;
         @(negedge clk);
         n_checks++;
         if (in_pop !== ((k == 0) ? 4'b0001 : 4'b0000)) begin
            n_fail++;
            $display("FAIL error_pop cycle %0d: got %b", k, in_pop);
         end
         n_checks++;
         if (out_push !== (k == 1)) begin
            n_fail++;
            $display("FAIL error_push cycle %0d: got %b, want %b", k, out_push, (k == 1));
         end
         if (k == 1) begin
            n_checks++;
            if (out_data !== 10'h010 || estado !== 2'd1) begin
               n_fail++;
               $display("FAIL error_pending: got data=%h estado=%0d, want 010 1", out_data, estado);
            end
         end
         if (k >= 2) begin
            n_checks++;
            if ({estado, err, idle} !== 4'b1010) begin
               n_fail++;
               $display("FAIL error_sticky cycle %0d: got estado=%0d err=%b idle=%b, want 2 1 0",
                        k, estado, err, idle);
            end
         end
         if (k == 3) begin
            n_checks++;
            if (fwd_count !== 16'd19) begin
               n_fail++;
               $display("FAIL error_fwd_count: got %0d, want 19", fwd_count);
            end
         end
         @(posedge clk); #1;
      end
   endtask
`endif

   task automatic test_out_error();
      // Reset mid-cycle, away from any clock edge.
      rst_n = 1'b0;
      #2;
      n_checks++;
      if ({estado, err, out_push, fwd_count} !== 20'd0) begin
         n_fail++;
         $display("FAIL async_reset: got estado=%0d err=%b push=%b fwd=%0d, want all 0",
                  estado, err, out_push, fwd_count);
      end
      @(posedge clk); #1;
      rst_n      = 1'b1;
      in_error   = 4'b0000;
      dst_drain  = 1'b0;
      force_full = 1'b1;
      load_word(0, 10'h155);
      force_full = 1'b0;
      for (int k = 0; k < 3; k++) begin
         out_error = (k == 0);
         @(negedge clk);
         n_checks++;
         if ({in_pop, out_push} !== 5'b0) begin
            n_fail++;
            $display("FAIL out_error_pop cycle %0d: got pop=%b push=%b, want 0000 0",
                     k, in_pop, out_push);
         end
         n_checks++;
         if (estado !== ((k == 0) ? 2'd0 : 2'd2)) begin
            n_fail++;
            $display("FAIL out_error_state cycle %0d: got %0d", k, estado);
         end
         @(posedge clk); #1;
      end
   endtask

   initial begin
      rst_n       = 1'b0;
      in_error    = 4'b0000;
      out_error   = 1'b0;
      force_full  = 1'b1;
      ld_en       = 1'b0;
      ld_idx      = 2'd0;
      ld_val      = 10'd0;
      dst_drain   = 1'b0;
      dst_set_en  = 1'b0;
      dst_set_val = 4'd0;
      test_reset();
`ifdef FIXED_PRIORITY_EN
      test_fixed_priority();
`else
      test_round_robin();
      test_single();
      test_throttle();
      test_error();
`endif
      test_out_error();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
